pipe_stage_buf: RTL and testbench

PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

---
 rtl/pipe_stage_buf.sv | 149 ++++++++++++++
 tb/tb_pipe_stage_buf.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// Pipeline stage buffer with valid/ready handshake: a head register feeding the
// outputs plus an optional skid entry so upstream ready need not follow out_ready.
module pipe_stage_buf #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [1:0]        occ_q, occ_d;
  logic [CTRL_W-1:0] head_ctrl_q, head_ctrl_d;
  logic [DATA_W-1:0] head_data_q, head_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              push;
  logic              pop;

  // Upstream ready: never a function of in_valid, so no combinational loop upstream
  always_comb begin
    if (SKID != 0) begin
      in_ready = (state_q != ST_TWO) && !flush;
    end else begin
      in_ready = (!out_valid_q || out_ready) && !flush;
    end
  end

  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid_q & out_ready & ~flush;

  // Next-state and next-contents; emptied slots are zeroed so outputs read zero when idle
  always_comb begin
    state_d     = state_q;
    head_ctrl_d = head_ctrl_q;
    head_data_d = head_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      state_d     = ST_EMPTY;
      head_ctrl_d = '0;
      head_data_d = '0;
      skid_ctrl_d = '0;
      skid_data_d = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            state_d     = ST_ONE;
            head_ctrl_d = in_ctrl;
            head_data_d = in_data;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            head_ctrl_d = in_ctrl;
            head_data_d = in_data;
          end else if (pop) begin
            state_d     = ST_EMPTY;
            head_ctrl_d = '0;
            head_data_d = '0;
          end else if (push && (SKID != 0)) begin
            state_d     = ST_TWO;
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_TWO: begin
          if (pop) begin
            state_d     = ST_ONE;
            head_ctrl_d = skid_ctrl_q;
            head_data_d = skid_data_q;
            skid_ctrl_d = '0;
            skid_data_d = '0;
          end else begin
            state_d = ST_TWO;
          end
        end
        default: begin
          state_d     = ST_EMPTY;
          head_ctrl_d = '0;
          head_data_d = '0;
          skid_ctrl_d = '0;
          skid_data_d = '0;
        end
      endcase
    end
  end

  // Registered status derived from the next state so it always matches the encoding
  always_comb begin
    out_valid_d = (state_d != ST_EMPTY);
    case (state_d)
      ST_EMPTY: occ_d = 2'd0;
      ST_ONE:   occ_d = 2'd1;
      ST_TWO:   occ_d = 2'd2;
      default:  occ_d = 2'd0;
    endcase
  end

  // State and storage registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      occ_q       <= 2'd0;
      head_ctrl_q <= '0;
      head_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      occ_q       <= occ_d;
      head_ctrl_q <= head_ctrl_d;
      head_data_q <= head_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_ctrl  = head_ctrl_q;
  assign out_data  = head_data_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: SKID=1 and SKID=0 instances share stimulus, each
// checked every cycle against its own queue-based reference model.
module tb_pipe_stage_buf;
  localparam int DW = 32;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;

  logic          in_ready1, out_valid1, in_ready0, out_valid0;
  logic [CW-1:0] out_ctrl1, out_ctrl0;
  logic [DW-1:0] out_data1, out_data0;
  logic [1:0]    occ1, occ0;

  int errors = 0;
  int checks = 0;
  int push_cnt1 = 0;
  int push_cnt0 = 0;
  logic [39:0] q1[$];
  logic [39:0] q0[$];

  pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
    .out_ctrl(out_ctrl1), .out_data(out_data1), .occupancy(occ1));

  pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
    .out_ctrl(out_ctrl0), .out_data(out_data0), .occupancy(occ0));

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_dut(input string pfx, input int sz, input logic [39:0] head,
                         input logic exp_rdy, input logic ir, input logic ov,
                         input logic [7:0] oc, input logic [31:0] od, input logic [1:0] occ);
    chk({pfx, "_in_ready"}, 64'(ir), 64'(exp_rdy));
    chk({pfx, "_out_valid"}, 64'(ov), 64'(sz != 0));
    chk({pfx, "_occupancy"}, 64'(occ), 64'(sz));
    if (sz != 0) begin
      chk({pfx, "_out_ctrl"}, 64'(oc), 64'(head[39:32]));
      chk({pfx, "_out_data"}, 64'(od), 64'(head[31:0]));
    end else begin
      chk({pfx, "_out_ctrl_zero"}, 64'(oc), 64'h0);
      chk({pfx, "_out_data_zero"}, 64'(od), 64'h0);
    end
  endtask

  // One clock cycle: check both DUTs against their models, then advance the models.
  task automatic tick();
    logic e_r1, e_r0, p1, p0, po1, po0;
    #1;
    e_r1 = (q1.size() < 2) && !flush;
    e_r0 = ((q0.size() == 0) || out_ready) && !flush;
    chk_dut("s1", q1.size(), (q1.size() != 0) ? q1[0] : 40'h0, e_r1,
            in_ready1, out_valid1, out_ctrl1, out_data1, occ1);
    chk_dut("s0", q0.size(), (q0.size() != 0) ? q0[0] : 40'h0, e_r0,
            in_ready0, out_valid0, out_ctrl0, out_data0, occ0);
    chk("s0_occ_le1", 64'(occ0 <= 2'd1), 64'h1);
    in_valid = ~in_valid;
    #1;
    chk("s1_rdy_indep_valid", 64'(in_ready1), 64'(e_r1));
    chk("s0_rdy_indep_valid", 64'(in_ready0), 64'(e_r0));
    in_valid = ~in_valid;
    #1;
    p1  = e_r1 && in_valid && !rst;
    p0  = e_r0 && in_valid && !rst;
    po1 = (q1.size() != 0) && out_ready && !flush && !rst;
    po0 = (q0.size() != 0) && out_ready && !flush && !rst;
    @(posedge clk);
    if (rst || flush) begin
      q1.delete();
      q0.delete();
    end else begin
      if (po1) void'(q1.pop_front());
      if (po0) void'(q0.pop_front());
      if (p1) begin q1.push_back({in_ctrl, in_data}); push_cnt1++; end
      if (p0) begin q0.push_back({in_ctrl, in_data}); push_cnt0++; end
    end
    #1;
  endtask

  initial begin
    int base1, base0;
    // Reset state, asynchronous: visible before any clock edge
    #1;
    chk("rst_out_valid", 64'(out_valid1), 64'h0);
    chk("rst_out_ctrl", 64'(out_ctrl1), 64'h0);
    chk("rst_out_data", 64'(out_data1), 64'h0);
    chk("rst_occupancy", 64'(occ1), 64'h0);
    tick();
    rst = 1'b0;

    // Push into EMPTY: visible next cycle
    out_ready = 1'b1; in_valid = 1'b1; in_ctrl = 8'hA5; in_data = 32'h11111111;
    tick();
    in_valid = 1'b0;
    chk("lat_out_valid", 64'(out_valid1), 64'h1);
    chk("lat_out_ctrl", 64'(out_ctrl1), 64'hA5);
    chk("lat_out_data", 64'(out_data1), 64'h11111111);
    chk("lat_occupancy", 64'(occ1), 64'h1);
    tick();

    // Fill skid with E1, E2; hold off E3; then drain in order
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 8'h01; in_data = 32'hE1E1E1E1;
    tick();
    in_ctrl = 8'h02; in_data = 32'hE2E2E2E2;
    tick();
    in_ctrl = 8'h03; in_data = 32'hE3E3E3E3;
    #1;
    chk("full_occupancy", 64'(occ1), 64'h2);
    chk("full_in_ready", 64'(in_ready1), 64'h0);
    tick();
    chk("held_occupancy", 64'(occ1), 64'h2);
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("drain_e1_ctrl", 64'(out_ctrl1), 64'h01);
    chk("drain_e1_data", 64'(out_data1), 64'hE1E1E1E1);
    tick();
    chk("drain_e2_ctrl", 64'(out_ctrl1), 64'h02);
    chk("drain_e2_data", 64'(out_data1), 64'hE2E2E2E2);
    tick();
    chk("drain_empty", 64'(out_valid1), 64'h0);

    // Full then flush with a simultaneous input entry
    out_ready = 1'b0; in_valid = 1'b1;
    in_ctrl = 8'hF1; in_data = 32'hF1F1F1F1;
    tick();
    in_ctrl = 8'hF2; in_data = 32'hF2F2F2F2;
    tick();
    flush = 1'b1; out_ready = 1'b1; in_ctrl = 8'hFF; in_data = 32'hDEADBEEF;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_occupancy", 64'(occ1), 64'h0);
    chk("flush_out_valid", 64'(out_valid1), 64'h0);
    chk("flush_out_ctrl", 64'(out_ctrl1), 64'h0);
    chk("flush_out_data", 64'(out_data1), 64'h0);
    tick();
    chk("flush_no_ghost", 64'(out_valid1), 64'h0);

    // Asynchronous reset pulse between edges while full
    out_ready = 1'b0; in_valid = 1'b1;
    in_ctrl = 8'h61; in_data = 32'h61616161;
    tick();
    in_ctrl = 8'h62; in_data = 32'h62626262;
    tick();
    in_valid = 1'b0;
    chk("pre_rst_occupancy", 64'(occ1), 64'h2);
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid1), 64'h0);
    chk("arst_out_ctrl", 64'(out_ctrl1), 64'h0);
    chk("arst_out_data", 64'(out_data1), 64'h0);
    chk("arst_occupancy", 64'(occ1), 64'h0);
    chk("arst_s0_out_valid", 64'(out_valid0), 64'h0);
    rst = 1'b0;
    q1.delete();
    q0.delete();

    // First push after release is accepted
    out_ready = 1'b1; in_valid = 1'b1; in_ctrl = 8'h71; in_data = 32'h71717171;
    tick();
    in_valid = 1'b0;
    chk("release_out_valid", 64'(out_valid1), 64'h1);
    chk("release_out_data", 64'(out_data1), 64'h71717171);
    tick();

    // Random streaming until each instance has accepted 1000 entries
    base1 = push_cnt1;
    base0 = push_cnt0;
    for (int c = 0; c < 20000 && (push_cnt1 < base1 + 1000 || push_cnt0 < base0 + 1000); c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      in_ctrl   = 8'($urandom);
      in_data   = $urandom;
      tick();
    end
    chk("stream_s1_count", 64'(push_cnt1 >= base1 + 1000), 64'h1);
    chk("stream_s0_count", 64'(push_cnt0 >= base0 + 1000), 64'h1);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) tick();

    // Sustained throughput with out_ready held high
    base1 = push_cnt1;
    base0 = push_cnt0;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_ctrl = 8'(i + 8'h80);
      in_data = 32'(i) ^ 32'hC0DE0000;
      tick();
    end
    chk("tput_s1", 64'(push_cnt1 - base1), 64'd20);
    chk("tput_s0", 64'(push_cnt0 - base0), 64'd20);
    in_valid = 1'b0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
